// File: rtl/risc16_mc_control.sv
// risc16_mc_control
// Multi-cycle control sequencer for the 16-bit, 8-register RISC datapath.
// It owns the PC and the instruction register. It steps each instruction
// through FETCH, DECODE, EXEC, MEM and WB as needed, shares one memory port
// between instruction fetch and lw/sw, and drives the register-file controls.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   mem_rdata    in   memory read data, captured into IR when a fetch completes
//   mem_ready    in   memory completes the current request this cycle
//   alu_out      in   ALU result; the datapath uses it as the lw/sw address
//   alu_eq       in   ALU equality flag, valid in EXEC
//   reg_out1     in   register-file read port 1 (jalr target)
//   ir           out  instruction register, feeds the register file
//   pc           out  program counter
//   mem_req      out  memory request valid
//   mem_we       out  memory write (sw only)
//   mem_addr_sel out  0: address = pc, 1: address = alu_out
//   alu_op       out  00 add, 01 nand, 10 compare
//   WE_rf        out  register-file write enable, one-cycle pulse in WB
//   MUX_tgt      out  write-back source: 00 mem, 01 alu, 10 pc+1
//   retire       out  one-cycle pulse when an instruction completes
//   halted       out  high while in HALT
module risc16_mc_control #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter bit          HALT_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  input  logic [15:0] alu_out,
  input  logic        alu_eq,
  input  logic [15:0] reg_out1,
  output logic [15:0] ir,
  output logic [15:0] pc,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic [1:0]  alu_op,
  output logic        WE_rf,
  output logic [1:0]  MUX_tgt,
  output logic        retire,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_LW   = 3'b100;
  localparam logic [2:0] OP_SW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_JALR = 3'b111;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  // Low for the first cycle after reset, so no request is raised while
  // the reset is still being released and a half-started transfer is dropped.
  logic        live_q;

  logic [2:0]  opcode;
  logic [15:0] imm_sext;
  logic [15:0] pc_inc;
  logic        is_halt;
  logic        active;

  // The memory address mux lives in the datapath; the controller only
  // selects it, so the ALU result is not consumed here.
  logic        unused_alu_out;
  assign unused_alu_out = ^alu_out;

  function automatic logic [1:0] alu_op_for(input logic [2:0] op);
    logic [1:0] r;
    case (op)
      OP_NAND: r = 2'b01;
      OP_BEQ:  r = 2'b10;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] wb_src_for(input logic [2:0] op);
    logic [1:0] r;
    case (op)
      OP_LW:   r = 2'b00;
      OP_JALR: r = 2'b10;
      default: r = 2'b01;
    endcase
    return r;
  endfunction

  assign opcode   = ir_q[15:13];
  assign imm_sext = {{9{ir_q[6]}}, ir_q[6:0]};
  assign pc_inc   = pc_q + 16'd1;
  assign is_halt  = HALT_EN && (opcode == OP_JALR) && (ir_q[6:0] != 7'd0);
  assign active   = live_q && !rst;

  // Next-state, PC/IR next values and all control strobes.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    alu_op       = 2'b00;
    WE_rf        = 1'b0;
    MUX_tgt      = 2'b00;
    retire       = 1'b0;
    halted       = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (active && mem_ready) begin
          ir_d    = mem_rdata;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        alu_op  = alu_op_for(opcode);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        alu_op = alu_op_for(opcode);
        if (opcode == OP_BEQ) begin
          pc_d    = alu_eq ? (pc_inc + imm_sext) : pc_inc;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if ((opcode == OP_LW) || (opcode == OP_SW)) begin
          state_d = S_MEM;
        end else if (is_halt) begin
          state_d = S_HALT;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        alu_op       = alu_op_for(opcode);
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (opcode == OP_SW);
        if (active && mem_ready) begin
          if (opcode == OP_SW) begin
            pc_d    = pc_inc;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB: begin
        alu_op  = alu_op_for(opcode);
        WE_rf   = 1'b1;
        MUX_tgt = wb_src_for(opcode);
        // The register file still sees the old pc this cycle, so the jalr
        // link value it writes is old pc + 1.
        pc_d    = (opcode == OP_JALR) ? reg_out1 : pc_inc;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        halted  = 1'b1;
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Everything stays quiet while reset is applied and for one cycle after.
    if (!active) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      alu_op       = 2'b00;
      WE_rf        = 1'b0;
      MUX_tgt      = 2'b00;
      retire       = 1'b0;
      halted       = 1'b0;
    end else begin
      halted = halted;
    end
  end

  // State, PC and IR registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      live_q  <= 1'b1;
    end
  end

  assign pc = pc_q;
  assign ir = ir_q;

endmodule
